// File: rtl/ddr3_mport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_mport_arbiter
// Brief    : Round-robin multi-port front end sharing one DDR3 controller
//            command port, with in-order read-return routing by tag FIFO.
// Revision : 1.0
// ============================================================================
module ddr3_mport_arbiter #(
  parameter int NPORTS    = 2,
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 128,
  parameter int MASK_W    = 16,
  parameter int TAG_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req_valid_i,
  output logic [NPORTS-1:0]        req_ready_o,
  input  logic [NPORTS-1:0]        req_we_i,
  input  logic [NPORTS*ADDR_W-1:0] req_addr_i,
  input  logic [NPORTS*DATA_W-1:0] req_wdata_i,
  input  logic [NPORTS*MASK_W-1:0] req_wmask_i,
  output logic [NPORTS-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]        rsp_data_o,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic                     cmd_we_o,
  output logic [ADDR_W-1:0]        cmd_addr_o,
  output logic [DATA_W-1:0]        cmd_wdata_o,
  output logic [MASK_W-1:0]        cmd_wmask_o,
  input  logic                     rd_valid_i,
  input  logic [DATA_W-1:0]        rd_data_i,
  output logic                     err_orphan_o
);

  localparam int C_PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int C_AW = $clog2(TAG_DEPTH);
  localparam int C_CW = C_AW + 1;

  // Per-port views of the flattened request buses
  logic [ADDR_W-1:0] addr_arr  [NPORTS];
  logic [DATA_W-1:0] wdata_arr [NPORTS];
  logic [MASK_W-1:0] wmask_arr [NPORTS];

  for (genvar p = 0; p < NPORTS; p++) begin : g_unpack
    assign addr_arr[p]  = req_addr_i[p*ADDR_W +: ADDR_W];
    assign wdata_arr[p] = req_wdata_i[p*DATA_W +: DATA_W];
    assign wmask_arr[p] = req_wmask_i[p*MASK_W +: MASK_W];
  end

  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_we_q,    cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q,  cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [MASK_W-1:0] cmd_wmask_q, cmd_wmask_d;
  logic [C_PW-1:0]   rr_q,        rr_d;
  logic [NPORTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic              err_q,       err_d;

  logic [C_PW-1:0]   tag_mem_q [TAG_DEPTH];
  logic [C_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [C_CW-1:0]   count_q;

  logic              tag_pop, tag_push, tag_full, slot_free;
  logic              grant_found, grant_valid;
  logic [C_PW-1:0]   grant_idx;
  logic [C_PW:0]     cand;
  logic [NPORTS-1:0] eligible;
  logic [C_CW-1:0]   count_post_pop;

  // Full test uses the post-pop count so a same-cycle return frees a slot
  assign tag_pop        = rd_valid_i & (count_q != '0);
  assign count_post_pop = count_q - C_CW'(tag_pop);
  assign tag_full       = (count_post_pop == C_CW'(TAG_DEPTH));
  assign slot_free      = ~cmd_valid_q | cmd_ready_i;
  assign eligible       = req_valid_i & (req_we_i | {NPORTS{~tag_full}});

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NPORTS; i++) begin
      cand = {1'b0, rr_q} + (C_PW+1)'(i);
      if (cand >= (C_PW+1)'(NPORTS)) begin
        cand = cand - (C_PW+1)'(NPORTS);
      end
      if (!grant_found && eligible[cand[C_PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[C_PW-1:0];
      end
    end
  end

  assign grant_valid = grant_found & slot_free & ~rst;
  assign tag_push    = grant_valid & ~req_we_i[grant_idx];

  always_comb begin
    req_ready_o = '0;
    if (grant_valid) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_wmask_d = cmd_wmask_q;
    rr_d        = rr_q;
    if (grant_valid) begin
      cmd_valid_d = 1'b1;
      cmd_we_d    = req_we_i[grant_idx];
      cmd_addr_d  = addr_arr[grant_idx];
      cmd_wdata_d = wdata_arr[grant_idx];
      cmd_wmask_d = wmask_arr[grant_idx];
      rr_d        = grant_idx;
    end else if (cmd_ready_i) begin
      cmd_valid_d = 1'b0;
    end

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_pop) begin
      rsp_valid_d[tag_mem_q[rd_ptr_q]] = 1'b1;
      rsp_data_d                       = rd_data_i;
    end
    err_d = err_q | (rd_valid_i & ~tag_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wmask_q <= '0;
      rr_q        <= C_PW'(NPORTS - 1);
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_wmask_q <= cmd_wmask_d;
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      if (tag_push) begin
        tag_mem_q[wr_ptr_q] <= grant_idx;
        wr_ptr_q            <= wr_ptr_q + C_AW'(1);
      end
      if (tag_pop) begin
        rd_ptr_q <= rd_ptr_q + C_AW'(1);
      end
      count_q <= count_q + C_CW'(tag_push) - C_CW'(tag_pop);
    end
  end

  assign cmd_valid_o  = cmd_valid_q;
  assign cmd_we_o     = cmd_we_q;
  assign cmd_addr_o   = cmd_addr_q;
  assign cmd_wdata_o  = cmd_wdata_q;
  assign cmd_wmask_o  = cmd_wmask_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign err_orphan_o = err_q;

endmodule
`default_nettype wire
